imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer between the single-cycle core's PC logic and the combinational instruction ROM (6-bit word address in, 32-bit instruction out, same-cycle).
- Owns the fetch PC, drives the ROM address, and buffers fetched words in a small prefetch FIFO.
- Delivers instructions to the decode side over a valid/ready handshake.
- Accepts branch/jump redirects, which flush stale prefetched words.

Parameters:
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
AW, 6, ROM word-address width; byte PC width is AW+2
RESET_PC, 0, byte address fetched first after reset (word-aligned)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
fetch_en  in  1  1 = fetching allowed; 0 = hold fetch PC, keep FIFO contents
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  AW+2  byte target; bits [1:0] ignored
imem_addr  out  AW  word address to instruction ROM (= fetch_pc[AW+1:2])
imem_instr  in  32  ROM data, valid same cycle as imem_addr
out_valid  out  1  head-of-FIFO instruction valid
out_ready  in  1  consumer accepts head this cycle
out_instr  out  32  head instruction
out_pc  out  AW+2  byte address of out_instr
busy_full  out  1  FIFO count == DEPTH (debug/stall visibility)

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO count = 0; rd/wr pointers = 0; state = IDLE.
  - out_valid = 0, busy_full = 0; out_instr/out_pc = 0.
  - imem_addr = RESET_PC[AW+1:2].
- States:
  - IDLE: exactly one cycle after reset release, no push; then RUN if fetch_en else HOLD.
  - RUN: fetching. Goes to HOLD when fetch_en=0.
  - HOLD: no push, fetch_pc frozen, FIFO still drains. Goes to RUN when fetch_en=1.
  - redirect is honoured in every state, including IDLE; the state is then chosen by fetch_en.
- pop = out_valid & out_ready.
- push = (state==RUN) & ~redirect & (count<DEPTH | pop).
  - Push writes {imem_instr, fetch_pc} at wr_ptr.
  - fetch_pc advances by 4, wrapping modulo 2^(AW+2) (0xFC -> 0x00 at AW=6).
- Latency: a word addressed on imem_addr in cycle N appears on out_valid/out_instr in cycle N+1 at the earliest.
- out_valid = (count != 0). out_instr/out_pc come combinationally from FIFO head registers.
- Full: count==DEPTH with no pop -> no push. fetch_pc and imem_addr hold, so no word is skipped or duplicated.
- Full with simultaneous pop: push and pop in the same cycle; count unchanged.
- Empty: out_valid=0; out_ready is ignored.
- Redirect (cycle R):
  - count <- 0; pointers reset; fetch_pc <- {redirect_pc[AW+1:2], 2'b00}; no push in R.
  - A pop in R still counts as consumed; the consumer owns that handshake.
  - Cycle R+1: out_valid=0; imem_addr = target word.
  - Cycle R+2: target instruction valid, if in RUN.
- Redirect while fetch_en=0: PC is updated, FIFO flushed, nothing fetched until fetch_en=1.
- Unmapped ROM words (X data) are buffered and passed through unchanged; no checking is done here.
- Reset mid-operation: all state clears immediately; in-flight FIFO contents are discarded.

Decomposition:
- Shared package (mips_lite_pkg): PC width, instruction width, FETCH_RESET_PC constant, fetch state enum {IDLE, RUN, HOLD}.
- One sub-module: fetch_fifo, a DEPTH-entry synchronous FIFO of {pc, instr} with push/pop/flush, count and full outputs.
- The controller owns fetch_pc, the state machine and the push decision.

Test Plan:
1. Reset, fetch_en=1, out_ready=1 with the program ROM attached -> first valid word is pc 0x00 / 0x20020005, then 0x04 / 0x2003000c, then 0x08 / 0x2067fff7, one per cycle with no gaps.
2. out_ready=0 for 4 cycles after the first valid word:
   - count saturates at 2, busy_full=1, imem_addr holds 0x02.
   - On release, words at 0x00, 0x04, 0x08 follow in order with none lost.
3. Redirect to 0x48 while the FIFO is full -> next cycle out_valid=0; following cycle pc 0x48 / 0x08000012; no pre-redirect word ever appears.
4. Redirect to 0xFD (AW=6) -> fetches pc 0xFC, then 0x00 / 0x20020005 (low bits ignored, wrap).
5. fetch_en=0 for 3 cycles mid-stream -> FIFO drains to empty, imem_addr frozen; on fetch_en=1, fetching resumes at the next sequential pc.
6. Assert reset for 1 cycle mid-stream with redirect and pop active -> out_valid=0 immediately; after release, IDLE for one cycle, then pc 0x00 / 0x20020005.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// Shared constants and types for the mips-lite instruction-fetch path.
// Holds the address/instruction widths, the reset fetch address and the fetch FSM state encoding.
package mips_lite_pkg;

   localparam int INSTR_W = 32;
   localparam int IMEM_AW = 6;
   localparam int PC_W    = IMEM_AW + 2;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding prefetched {instr, pc} words.
// The head entry is exposed combinationally; flush empties it in one cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 40
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [W-1:0]           i_wdata,
   output logic [W-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_pop;
   logic w_push;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A pop on an empty FIFO is ignored; a push into a full FIFO needs a pop alongside it.
   assign w_pop  = i_pop & (r_count != '0) & ~i_flush;
   assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

   // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is reset on purpose -- the head entry drives out_instr/out_pc, which must read 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the combinational ROM,
// buffers fetched words in a prefetch FIFO and hands them to decode over valid/ready.
module imem_fetch_ctrl
   import mips_lite_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter int          AW       = IMEM_AW,
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   input  logic               redirect,
   input  logic [AW+1:0]      redirect_pc,
   output logic [AW-1:0]      imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [AW+1:0]      out_pc,
   output logic               busy_full
);

   localparam int PCW   = AW + 2;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = INSTR_W + PCW;

   localparam logic [PCW-1:0] RESET_PC_W = RESET_PC[PCW-1:0];

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [PCW-1:0]   r_fetch_pc;
   logic [PCW-1:0]   w_target_pc;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic [ENT_W-1:0] w_head;

   // Byte-offset bits of the redirect target are dropped; fetches are always word-aligned.
   assign w_target_pc = redirect_pc & ~PCW'(3);

   assign imem_addr = r_fetch_pc[PCW-1:2];
   assign out_valid = (w_count != '0);
   assign w_pop     = out_valid & out_ready;
   assign busy_full = w_full;
   assign out_instr = w_head[ENT_W-1:PCW];
   assign out_pc    = w_head[PCW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // IDLE lasts exactly one cycle; afterwards fetch_en alone picks RUN or HOLD, redirect or not.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = fetch_en ? RUN : HOLD;
         RUN:     if (!fetch_en) w_state_nxt = HOLD;
         HOLD:    if (fetch_en)  w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_push = 1'b0;
      if (r_state == RUN && !redirect) w_push = !w_full || w_pop;
   end

   // The PC advances only on a real push, so a full FIFO stalls fetch without skipping a word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_fetch_pc <= RESET_PC_W;
      else if (redirect) r_fetch_pc <= w_target_pc;
      else if (w_push)   r_fetch_pc <= r_fetch_pc + PCW'(4);
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_wdata ({imem_instr, r_fetch_pc}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full)
   );

endmodule
